branch_resolve_tracker: RTL and testbench
=========================================

// Module: branch_resolve_tracker
// PURPOSE
// - Producer side of the branch-predictor update interface. Captures each IF-stage prediction in an in-order queue,
//   matches it to its EX-stage resolution, and drives the predictor/chooser update bundle (is_branch_ex, pc_ex,
//   cmp_out_ex, glob_/loc_predict_taken_ex) plus mispredict/redirect to fetch.
// - Sits between fetch (predictor read port) and execute (branch comparator).
// PARAMETERS
// - DEPTH   4   in-flight branch entries; power of 2, >=2
// - CNT_W   32  perf counter width (only with BRANCH_PERF_CNT_EN)
// PORTS
// - clk                    in   1   clock
// - rst                    in   1   reset; asynchronous, active-high
// - is_branch_if           in   1   branch in IF this cycle (push request)
// - pc_if                  in   32  IF branch PC
// - predict_taken_if       in   1   final (chosen) direction prediction
// - glob_predict_taken_if  in   1   global component prediction
// - loc_predict_taken_if   in   1   local component prediction
// - valid_branch_if        in   1   BTB tag hit
// - pred_target_if         in   32  predicted target
// - stall_if               in   1   IF stalled; suppresses push
// - flush                  in   1   external flush (trap); clears queue
// - resolve_ex             in   1   branch resolved in EX (pop)
// - resolve_pc_ex          in   32  PC of resolving branch
// - cmp_out_ex_in          in   1   actual direction
// - target_ex_in           in   32  actual target
// - full                   out  1   queue full (comb); fetch must stall
// - is_branch_ex           out  1   update valid, 1 cycle
// - pc_ex                  out  32  update PC (queued pc_if)
// - cmp_out_ex             out  1   actual direction
// - glob_predict_taken_ex  out  1   queued global prediction
// - loc_predict_taken_ex   out  1   queued local prediction
// - mispredict             out  1   redirect pulse, 1 cycle
// - redirect_pc            out  32  correct next PC when mispredict
// - order_err              out  1   sticky: pop on empty or PC mismatch
// BEHAVIOUR
// - Reset: queue empty, head=tail=0, all outputs 0 (full=0, order_err=0).
// - Push: is_branch_if & ~stall_if & ~full writes {pc,pred,glob,loc,valid,target} at tail. Push when full dropped.
// - Pop: resolve_ex removes head. Push+pop same cycle legal, incl. when full (full is not relaxed by same-cycle pop).
// - Update outputs are registered: asserted the cycle after resolve_ex, for exactly one cycle; else is_branch_ex=0.
// - eff_pred = predict_taken & valid_branch. mispredict = cmp_out != eff_pred | (cmp_out & target_ex_in != pred_target).
// - redirect_pc = cmp_out ? target_ex_in : resolve_pc_ex + 32'd4 (mod 2^32). Registered with mispredict.
// - Mispredict at resolve edge: head popped, all younger entries discarded, same-cycle push dropped (wrong path).
// - flush: clears queue at next edge; beats simultaneous push; same-cycle resolve still updates, but no mispredict
//   (external redirect owns fetch).
// - resolve_ex when empty: no update, order_err<=1. Head PC != resolve_pc_ex: update emitted with queued
//   data, order_err<=1. order_err clears only on rst.
// - Pointers wrap mod DEPTH; occupancy counter width $clog2(DEPTH)+1.
// - rst mid-operation: immediate clear of queue and registered outputs.
// CONFIGURATION
// - BRANCH_PERF_CNT_EN defined: outputs perf_branches, perf_mispredicts, perf_glob_correct, perf_loc_correct
//   [CNT_W-1:0], incremented per valid update; saturate at all-ones; reset to 0.
// - Undefined: ports and counters absent; all other behaviour identical.
// STRUCTURE
// - Shared package branch_pkg: typedef struct packed branch_entry_t {pc, predict_taken, glob, loc, valid_branch,
//   target}; localparam PC_STEP = 32'd4.
// - Sub-module branch_entry_fifo (DEPTH-entry queue: push/pop/clear, full/empty); top holds compare/update logic.
// TESTING
// - Push pc=0x100 pred=1 glob=1 loc=0 valid=1 tgt=0x200; resolve taken tgt=0x200 -> next cycle is_branch_ex=1,
//   pc_ex=0x100, glob=1, loc=0, mispredict=0.
// - Same entry, resolve not-taken -> mispredict=1, redirect_pc=0x104; 3 younger entries dropped; later resolve
//   on empty -> order_err=1.
// - Push 4 branches with no resolve -> full=1; 5th push dropped; push+resolve together keeps count 4.
// - Predicted taken, valid=0, actual taken tgt=0x300 -> mispredict=1, redirect_pc=0x300.
// - flush with push same cycle -> queue empty next cycle, full=0, no update.
// - rst asserted mid-resolve -> all outputs 0 without clock edge; BRANCH_PERF_CNT_EN: 10 updates, 3 mispredicts
//   -> perf_branches=10, perf_mispredicts=3.

Source files
------------

// File: rtl/branch_pkg.sv
`default_nettype none
// ============================================================================
// Package    : branch_pkg
// Description: Shared types and constants for the branch resolve tracker.
//              branch_entry_t is one in-flight prediction captured at IF.
//              entry_mispredicts() compares a queued prediction against the
//              EX-stage outcome.
// Revision   : 1.0 - initial release
// ============================================================================
package branch_pkg;

  // Sequential fall-through distance for a not-taken branch.
  localparam logic [31:0] PC_STEP = 32'd4;

  typedef struct packed {
    logic [31:0] pc;
    logic        predict_taken;
    logic        glob;
    logic        loc;
    logic        valid_branch;
    logic [31:0] target;
  } branch_entry_t;

  // A prediction without a BTB hit cannot redirect fetch, so it behaves as
  // not-taken. A correct taken direction still mispredicts when the target
  // disagrees.
  function automatic logic entry_mispredicts(
    input branch_entry_t e,
    input logic          actual_taken,
    input logic [31:0]   actual_target
  );
    logic eff_pred;
    eff_pred = e.predict_taken & e.valid_branch;
    return (actual_taken != eff_pred) |
           (actual_taken & (actual_target != e.target));
  endfunction

endpackage
`default_nettype wire

// File: rtl/branch_entry_fifo.sv
`default_nettype none
// ============================================================================
// Module     : branch_entry_fifo
// Description: DEPTH-entry in-order queue of branch predictions. Clear has
//              priority over push and pop. A push and a pop may happen in the
//              same cycle, including when the queue is full (the slot being
//              read out is the one being overwritten).
// Ports      : clk, rst (async, active-high)
//              push, push_data      - enqueue at tail
//              pop                  - dequeue head
//              clear                - drop all entries, pointers to 0
//              head_data            - entry at head (valid when !empty)
//              full, empty          - occupancy flags
// Revision   : 1.0 - initial release
// ============================================================================
import branch_pkg::*;

module branch_entry_fifo #(
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  branch_entry_t push_data,
  input  logic          pop,
  input  logic          clear,
  output branch_entry_t head_data,
  output logic          full,
  output logic          empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;

  branch_entry_t mem_q [DEPTH];
  branch_entry_t mem_d [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [OCC_W-1:0] count_q, count_d;

  always_comb begin
    mem_d   = mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (clear) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) begin
        mem_d[tail_q] = push_data;
        tail_d        = tail_q + PTR_W'(1);
      end
      if (pop) begin
        head_d = head_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + OCC_W'(1);
        2'b01:   count_d = count_q - OCC_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q   <= '{default: '0};
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign head_data = mem_q[head_q];
  assign full      = (count_q == OCC_W'(DEPTH));
  assign empty     = (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/branch_resolve_tracker.sv
`default_nettype none
// ============================================================================
// Module     : branch_resolve_tracker
// Description: Queues each IF-stage branch prediction, pairs it in order with
//              its EX-stage resolution and drives the predictor update bundle
//              plus a mispredict redirect to fetch.
// Ports      : clk, rst (async, active-high)
//              IF side : is_branch_if, pc_if, predict_taken_if,
//                        glob_predict_taken_if, loc_predict_taken_if,
//                        valid_branch_if, pred_target_if, stall_if, full
//              EX side : resolve_ex, resolve_pc_ex, cmp_out_ex_in,
//                        target_ex_in
//              Control : flush
//              Update  : is_branch_ex, pc_ex, cmp_out_ex,
//                        glob_predict_taken_ex, loc_predict_taken_ex,
//                        mispredict, redirect_pc, order_err
// Options    : BRANCH_PERF_CNT_EN adds saturating perf counters
//              perf_branches, perf_mispredicts, perf_glob_correct,
//              perf_loc_correct (CNT_W bits each).
// Revision   : 1.0 - initial release
// ============================================================================
import branch_pkg::*;

module branch_resolve_tracker #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             is_branch_if,
  input  logic [31:0]      pc_if,
  input  logic             predict_taken_if,
  input  logic             glob_predict_taken_if,
  input  logic             loc_predict_taken_if,
  input  logic             valid_branch_if,
  input  logic [31:0]      pred_target_if,
  input  logic             stall_if,
  input  logic             flush,
  input  logic             resolve_ex,
  input  logic [31:0]      resolve_pc_ex,
  input  logic             cmp_out_ex_in,
  input  logic [31:0]      target_ex_in,
  output logic             full,
  output logic             is_branch_ex,
  output logic [31:0]      pc_ex,
  output logic             cmp_out_ex,
  output logic             glob_predict_taken_ex,
  output logic             loc_predict_taken_ex,
  output logic             mispredict,
  output logic [31:0]      redirect_pc,
  output logic             order_err
`ifdef BRANCH_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] perf_branches,
  output logic [CNT_W-1:0] perf_mispredicts,
  output logic [CNT_W-1:0] perf_glob_correct,
  output logic [CNT_W-1:0] perf_loc_correct
`endif
);

  branch_entry_t push_entry;
  branch_entry_t head_entry;
  logic          fifo_full;
  logic          fifo_empty;
  logic          pop;
  logic          push;
  logic          clear;
  logic          mispredict_now;

  assign push_entry = '{
    pc:            pc_if,
    predict_taken: predict_taken_if,
    glob:          glob_predict_taken_if,
    loc:           loc_predict_taken_if,
    valid_branch:  valid_branch_if,
    target:        pred_target_if
  };

  assign pop            = resolve_ex & ~fifo_empty;
  assign mispredict_now = pop & entry_mispredicts(head_entry, cmp_out_ex_in, target_ex_in);
  // A mispredict means everything younger than the head is wrong-path.
  assign clear          = flush | mispredict_now;
  // full stays asserted to fetch, but a same-cycle pop frees the head slot so
  // the push can still be accepted into it.
  assign push           = is_branch_if & ~stall_if & (~fifo_full | pop) & ~clear;
  assign full           = fifo_full;

  branch_entry_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .clear     (clear),
    .head_data (head_entry),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  logic        is_branch_ex_q, is_branch_ex_d;
  logic [31:0] pc_ex_q, pc_ex_d;
  logic        cmp_out_ex_q, cmp_out_ex_d;
  logic        glob_predict_taken_ex_q, glob_predict_taken_ex_d;
  logic        loc_predict_taken_ex_q, loc_predict_taken_ex_d;
  logic        mispredict_q, mispredict_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;
  logic        order_err_q, order_err_d;

  always_comb begin
    is_branch_ex_d          = pop;
    pc_ex_d                 = pc_ex_q;
    cmp_out_ex_d            = cmp_out_ex_q;
    glob_predict_taken_ex_d = glob_predict_taken_ex_q;
    loc_predict_taken_ex_d  = loc_predict_taken_ex_q;
    // During flush the external redirect owns fetch, so no redirect pulse.
    mispredict_d            = mispredict_now & ~flush;
    redirect_pc_d           = redirect_pc_q;
    order_err_d             = order_err_q;

    if (pop) begin
      pc_ex_d                 = head_entry.pc;
      cmp_out_ex_d            = cmp_out_ex_in;
      glob_predict_taken_ex_d = head_entry.glob;
      loc_predict_taken_ex_d  = head_entry.loc;
    end

    if (mispredict_d) begin
      redirect_pc_d = cmp_out_ex_in ? target_ex_in : (resolve_pc_ex + PC_STEP);
    end

    // Resolving with nothing queued, or out of order, is a pipeline bug.
    if (resolve_ex && (fifo_empty || (head_entry.pc != resolve_pc_ex))) begin
      order_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      is_branch_ex_q          <= 1'b0;
      pc_ex_q                 <= '0;
      cmp_out_ex_q            <= 1'b0;
      glob_predict_taken_ex_q <= 1'b0;
      loc_predict_taken_ex_q  <= 1'b0;
      mispredict_q            <= 1'b0;
      redirect_pc_q           <= '0;
      order_err_q             <= 1'b0;
    end else begin
      is_branch_ex_q          <= is_branch_ex_d;
      pc_ex_q                 <= pc_ex_d;
      cmp_out_ex_q            <= cmp_out_ex_d;
      glob_predict_taken_ex_q <= glob_predict_taken_ex_d;
      loc_predict_taken_ex_q  <= loc_predict_taken_ex_d;
      mispredict_q            <= mispredict_d;
      redirect_pc_q           <= redirect_pc_d;
      order_err_q             <= order_err_d;
    end
  end

  assign is_branch_ex          = is_branch_ex_q;
  assign pc_ex                 = pc_ex_q;
  assign cmp_out_ex            = cmp_out_ex_q;
  assign glob_predict_taken_ex = glob_predict_taken_ex_q;
  assign loc_predict_taken_ex  = loc_predict_taken_ex_q;
  assign mispredict            = mispredict_q;
  assign redirect_pc           = redirect_pc_q;
  assign order_err             = order_err_q;

`ifdef BRANCH_PERF_CNT_EN
  logic [CNT_W-1:0] perf_branches_q, perf_branches_d;
  logic [CNT_W-1:0] perf_mispredicts_q, perf_mispredicts_d;
  logic [CNT_W-1:0] perf_glob_correct_q, perf_glob_correct_d;
  logic [CNT_W-1:0] perf_loc_correct_q, perf_loc_correct_d;

  // Counters follow the emitted update, so they saturate at all-ones.
  always_comb begin
    perf_branches_d     = perf_branches_q;
    perf_mispredicts_d  = perf_mispredicts_q;
    perf_glob_correct_d = perf_glob_correct_q;
    perf_loc_correct_d  = perf_loc_correct_q;
    if (pop) begin
      if (!(&perf_branches_q)) begin
        perf_branches_d = perf_branches_q + CNT_W'(1);
      end
      if (mispredict_d && !(&perf_mispredicts_q)) begin
        perf_mispredicts_d = perf_mispredicts_q + CNT_W'(1);
      end
      if ((head_entry.glob == cmp_out_ex_in) && !(&perf_glob_correct_q)) begin
        perf_glob_correct_d = perf_glob_correct_q + CNT_W'(1);
      end
      if ((head_entry.loc == cmp_out_ex_in) && !(&perf_loc_correct_q)) begin
        perf_loc_correct_d = perf_loc_correct_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_branches_q     <= '0;
      perf_mispredicts_q  <= '0;
      perf_glob_correct_q <= '0;
      perf_loc_correct_q  <= '0;
    end else begin
      perf_branches_q     <= perf_branches_d;
      perf_mispredicts_q  <= perf_mispredicts_d;
      perf_glob_correct_q <= perf_glob_correct_d;
      perf_loc_correct_q  <= perf_loc_correct_d;
    end
  end

  assign perf_branches     = perf_branches_q;
  assign perf_mispredicts  = perf_mispredicts_q;
  assign perf_glob_correct = perf_glob_correct_q;
  assign perf_loc_correct  = perf_loc_correct_q;
`else
  // Perf counters are not built; CNT_W only sizes them when enabled.
  if (CNT_W > 0) begin : g_no_perf_cnt
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_branch_resolve_tracker.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module     : tb_branch_resolve_tracker
// Description: Self-checking bench for branch_resolve_tracker. A queue-based
//              reference model predicts every registered output; directed
//              scenarios pin the model with literal values, then a random
//              phase exercises push/pop/flush/mispredict interleavings.
// Revision   : 1.0 - initial release
// ============================================================================
module tb_branch_resolve_tracker;

  localparam int DEPTH = 4;
  localparam int CNT_W = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        is_branch_if, predict_taken_if, glob_predict_taken_if;
  logic        loc_predict_taken_if, valid_branch_if, stall_if, flush;
  logic [31:0] pc_if, pred_target_if, resolve_pc_ex, target_ex_in;
  logic        resolve_ex, cmp_out_ex_in;
  logic        full, is_branch_ex, cmp_out_ex, glob_predict_taken_ex;
  logic        loc_predict_taken_ex, mispredict, order_err;
  logic [31:0] pc_ex, redirect_pc;
`ifdef BRANCH_PERF_CNT_EN
  logic [CNT_W-1:0] perf_branches, perf_mispredicts, perf_glob_correct, perf_loc_correct;
`endif

  always #5 clk = ~clk;

  branch_resolve_tracker #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk                   (clk),
    .rst                   (rst),
    .is_branch_if          (is_branch_if),
    .pc_if                 (pc_if),
    .predict_taken_if      (predict_taken_if),
    .glob_predict_taken_if (glob_predict_taken_if),
    .loc_predict_taken_if  (loc_predict_taken_if),
    .valid_branch_if       (valid_branch_if),
    .pred_target_if        (pred_target_if),
    .stall_if              (stall_if),
    .flush                 (flush),
    .resolve_ex            (resolve_ex),
    .resolve_pc_ex         (resolve_pc_ex),
    .cmp_out_ex_in         (cmp_out_ex_in),
    .target_ex_in          (target_ex_in),
    .full                  (full),
    .is_branch_ex          (is_branch_ex),
    .pc_ex                 (pc_ex),
    .cmp_out_ex            (cmp_out_ex),
    .glob_predict_taken_ex (glob_predict_taken_ex),
    .loc_predict_taken_ex  (loc_predict_taken_ex),
    .mispredict            (mispredict),
    .redirect_pc           (redirect_pc),
    .order_err             (order_err)
`ifdef BRANCH_PERF_CNT_EN
    ,
    .perf_branches         (perf_branches),
    .perf_mispredicts      (perf_mispredicts),
    .perf_glob_correct     (perf_glob_correct),
    .perf_loc_correct      (perf_loc_correct)
`endif
  );

  // Reference model: a plain queue of predictions plus expected outputs.
  typedef struct {
    logic [31:0] pc;
    bit          pred;
    bit          glob;
    bit          loc;
    bit          vld;
    logic [31:0] tgt;
  } ent_t;

  ent_t        mq[$];
  bit          m_err, m_upd, m_mis, m_cmp, m_glob, m_loc;
  logic [31:0] m_pc, m_redir;
  int          m_br, m_mp, m_gc, m_lc;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_idle();
    is_branch_if = 0; pc_if = '0; predict_taken_if = 0; glob_predict_taken_if = 0;
    loc_predict_taken_if = 0; valid_branch_if = 0; pred_target_if = '0; stall_if = 0;
    flush = 0; resolve_ex = 0; resolve_pc_ex = '0; cmp_out_ex_in = 0; target_ex_in = '0;
  endtask

  task automatic push_in(input logic [31:0] pc, input bit pr, input bit g, input bit l,
                         input bit v, input logic [31:0] t);
    is_branch_if = 1; pc_if = pc; predict_taken_if = pr; glob_predict_taken_if = g;
    loc_predict_taken_if = l; valid_branch_if = v; pred_target_if = t;
  endtask

  task automatic resolve_in(input logic [31:0] pc, input bit c, input logic [31:0] t);
    resolve_ex = 1; resolve_pc_ex = pc; cmp_out_ex_in = c; target_ex_in = t;
  endtask

  // Apply the clock edge's effect to the model, using the inputs held for it.
  task automatic model_step();
    bit   pop_ok, mis;
    ent_t h, n;
    m_upd = 0; m_mis = 0; mis = 0;
    pop_ok = resolve_ex && (mq.size() > 0);
    if (resolve_ex && mq.size() == 0) m_err = 1;
    if (pop_ok) begin
      h = mq[0];
      if (h.pc != resolve_pc_ex) m_err = 1;
      mis = (cmp_out_ex_in != (h.pred && h.vld)) || (cmp_out_ex_in && (target_ex_in != h.tgt));
      m_upd = 1; m_pc = h.pc; m_cmp = cmp_out_ex_in; m_glob = h.glob; m_loc = h.loc;
      if (mis && !flush) begin
        m_mis   = 1;
        m_redir = cmp_out_ex_in ? target_ex_in : resolve_pc_ex + 32'd4;
      end
      m_br++;
      if (m_mis) m_mp++;
      if (h.glob == cmp_out_ex_in) m_gc++;
      if (h.loc == cmp_out_ex_in) m_lc++;
    end
    if (flush || mis) begin
      mq.delete();
    end else begin
      if (pop_ok) void'(mq.pop_front());
      if (is_branch_if && !stall_if && mq.size() < DEPTH) begin
        n.pc = pc_if; n.pred = predict_taken_if; n.glob = glob_predict_taken_if;
        n.loc = loc_predict_taken_if; n.vld = valid_branch_if; n.tgt = pred_target_if;
        mq.push_back(n);
      end
    end
  endtask

  // One clock: called at a negedge with inputs set; returns at next negedge.
  task automatic tick();
    chk("full", full, (mq.size() == DEPTH));
    @(posedge clk);
    model_step();
    #1;
    chk("is_branch_ex", is_branch_ex, m_upd);
    chk("mispredict", mispredict, m_mis);
    chk("order_err", order_err, m_err);
    if (m_upd) begin
      chk("pc_ex", pc_ex, m_pc);
      chk("cmp_out_ex", cmp_out_ex, m_cmp);
      chk("glob_ex", glob_predict_taken_ex, m_glob);
      chk("loc_ex", loc_predict_taken_ex, m_loc);
    end
    if (m_mis) chk("redirect_pc", redirect_pc, m_redir);
    @(negedge clk);
    set_idle();
  endtask

  // Asserts rst between edges and checks the asynchronous clear.
  task automatic do_reset();
    rst = 1;
    #1;
    chk("rst_is_branch_ex", is_branch_ex, 0);
    chk("rst_pc_ex", pc_ex, 0);
    chk("rst_mispredict", mispredict, 0);
    chk("rst_redirect_pc", redirect_pc, 0);
    chk("rst_order_err", order_err, 0);
    chk("rst_full", full, 0);
    chk("rst_cmp_glob_loc", {cmp_out_ex, glob_predict_taken_ex, loc_predict_taken_ex}, 0);
    mq.delete();
    m_err = 0; m_br = 0; m_mp = 0; m_gc = 0; m_lc = 0;
    @(negedge clk);
    rst = 0;
    set_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    set_idle();
    @(negedge clk);
    do_reset();

    // Correctly predicted taken branch.
    push_in(32'h100, 1, 1, 0, 1, 32'h200); tick();
    resolve_in(32'h100, 1, 32'h200); tick();
    chk("t1_valid", is_branch_ex, 1);
    chk("t1_pc", pc_ex, 32'h100);
    chk("t1_glob_loc", {glob_predict_taken_ex, loc_predict_taken_ex}, 2'b10);
    chk("t1_mispredict", mispredict, 0);

    // Mispredict flushes younger entries; following resolve hits empty.
    push_in(32'h100, 1, 1, 0, 1, 32'h200); tick();
    push_in(32'h110, 0, 0, 0, 1, 32'h0); tick();
    push_in(32'h120, 0, 0, 0, 1, 32'h0); tick();
    push_in(32'h130, 0, 0, 0, 1, 32'h0); tick();
    resolve_in(32'h100, 0, 32'h0); tick();
    chk("t2_mispredict", mispredict, 1);
    chk("t2_redirect", redirect_pc, 32'h104);
    chk("t2_full", full, 0);
    resolve_in(32'h110, 0, 32'h0); tick();
    chk("t2_empty_valid", is_branch_ex, 0);
    chk("t2_order_err", order_err, 1);
    do_reset();

    // Fill, overflow drop, then push+pop while full.
    for (int i = 0; i < 4; i++) begin
      push_in(32'h300 + 32'(4 * i), 0, 0, 1, 1, 32'h0); tick();
    end
    chk("t3_full", full, 1);
    push_in(32'h150, 0, 0, 0, 1, 32'h0); tick();
    push_in(32'h400, 0, 0, 0, 1, 32'h0); resolve_in(32'h300, 0, 32'h0); tick();
    chk("t3_full_kept", full, 1);
    chk("t3_pc", pc_ex, 32'h300);
    resolve_in(32'h304, 0, 32'h0); tick();
    resolve_in(32'h308, 0, 32'h0); tick();
    resolve_in(32'h30c, 0, 32'h0); tick();
    resolve_in(32'h400, 0, 32'h0); tick();
    chk("t3_last_pc", pc_ex, 32'h400);
    chk("t3_order_err", order_err, 0);

    // Taken prediction without BTB hit behaves as not-taken.
    push_in(32'h500, 1, 1, 1, 0, 32'h0); tick();
    resolve_in(32'h500, 1, 32'h300); tick();
    chk("t4_mispredict", mispredict, 1);
    chk("t4_redirect", redirect_pc, 32'h300);

    // Flush beats simultaneous push.
    push_in(32'h600, 0, 0, 0, 1, 32'h0); tick();
    push_in(32'h700, 0, 0, 0, 1, 32'h0); flush = 1; tick();
    chk("t5_full", full, 0);
    chk("t5_no_update", is_branch_ex, 0);
    resolve_in(32'h600, 0, 32'h0); tick();
    chk("t5_empty_valid", is_branch_ex, 0);
    chk("t5_order_err", order_err, 1);
    do_reset();

    // Asynchronous reset while update/redirect outputs are live.
    push_in(32'h800, 1, 0, 1, 1, 32'h900); tick();
    resolve_in(32'h800, 0, 32'h0); tick();
    chk("t6_mispredict", mispredict, 1);
    chk("t6_redirect", redirect_pc, 32'h804);
    resolve_in(32'h800, 0, 32'h0);
    #2;
    do_reset();

    // Ten updates, three of them mispredicted.
    for (int i = 0; i < 10; i++) begin
      push_in(32'hA00 + 32'(4 * i), 0, 0, 1, 1, 32'h0); tick();
      resolve_in(32'hA00 + 32'(4 * i), (i < 3), 32'hB00); tick();
    end
`ifdef BRANCH_PERF_CNT_EN
    chk("perf_branches_10", perf_branches, 10);
    chk("perf_mispredicts_3", perf_mispredicts, 3);
    chk("perf_loc_correct_3", perf_loc_correct, 3);
    chk("perf_glob_correct_7", perf_glob_correct, 7);
`endif
    do_reset();

    // Random interleaving.
    for (int i = 0; i < 3000; i++) begin
      is_branch_if          = ($urandom_range(0, 1) == 1);
      pc_if                 = 32'($urandom_range(0, 255)) << 2;
      predict_taken_if      = ($urandom_range(0, 1) == 1);
      glob_predict_taken_if = ($urandom_range(0, 1) == 1);
      loc_predict_taken_if  = ($urandom_range(0, 1) == 1);
      valid_branch_if       = ($urandom_range(0, 3) != 0);
      pred_target_if        = 32'($urandom_range(0, 7)) << 4;
      stall_if              = ($urandom_range(0, 9) == 0);
      flush                 = ($urandom_range(0, 49) == 0);
      resolve_ex            = ($urandom_range(0, 2) == 0);
      cmp_out_ex_in         = ($urandom_range(0, 1) == 1);
      resolve_pc_ex         = (mq.size() > 0 && $urandom_range(0, 19) != 0)
                              ? mq[0].pc : 32'($urandom_range(0, 255)) << 2;
      target_ex_in          = (mq.size() > 0 && $urandom_range(0, 3) != 0)
                              ? mq[0].tgt : 32'($urandom_range(0, 7)) << 4;
      tick();
`ifdef BRANCH_PERF_CNT_EN
      if (i % 500 == 498) begin
        chk("perf_branches", perf_branches, m_br);
        chk("perf_mispredicts", perf_mispredicts, m_mp);
        chk("perf_glob_correct", perf_glob_correct, m_gc);
        chk("perf_loc_correct", perf_loc_correct, m_lc);
      end
`endif
      if (i % 500 == 499) do_reset();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
